// File: rtl/secuenciador_bus_rtc.sv
// Sequencer for one RTC bus cycle (write or read) on the multiplexed AD bus.
// Optional macro BUS_RTC_ERROR_OCUPADO_EN adds the error_ocupado output.
module secuenciador_bus_rtc #(
   parameter int T_ALE   = 2,
   parameter int T_HOLD  = 1,
   parameter int T_PULSO = 4,
   parameter int T_REC   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inicio,
   input  logic       escritura,
   input  logic [7:0] direccion_in,
   input  logic [7:0] dato_in,
   input  logic [7:0] bus_in,
   output logic [7:0] direccion,
   output logic [7:0] dato,
   output logic       seleccion,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       ale,
   output logic       wr_n,
   output logic       rd_n,
   output logic [7:0] dato_leido,
   output logic       ocupado,
`ifdef BUS_RTC_ERROR_OCUPADO_EN
   output logic       error_ocupado,
`endif
   output logic       listo,
   output logic [2:0] estado_dbg
);

   // Phase lengths, with 0 promoted to 1 so every phase lasts at least a cycle.
   localparam logic [7:0] L_ALE   = (T_ALE   < 1) ? 8'd1 : 8'(T_ALE);
   localparam logic [7:0] L_HOLD  = (T_HOLD  < 1) ? 8'd1 : 8'(T_HOLD);
   localparam logic [7:0] L_PULSO = (T_PULSO < 1) ? 8'd1 : 8'(T_PULSO);
   localparam logic [7:0] L_REC   = (T_REC   < 1) ? 8'd1 : 8'(T_REC);

   typedef enum logic [2:0] {IDLE, DIR, RET, ESC, LEE, REC} estado_t;

   estado_t    estado_q, estado_d;
   logic [7:0] cnt_q, cnt_d;
   logic       esc_q, esc_d;
   logic [7:0] direccion_q, direccion_d;
   logic [7:0] dato_q, dato_d;
   logic [7:0] leido_q, leido_d;
   logic       listo_q, listo_d;
   logic       ocupado_q, ocupado_d;
   logic       cs_n_q, cs_n_d;
   logic       ale_q, ale_d;
   logic       wr_n_q, wr_n_d;
   logic       rd_n_q, rd_n_d;
   logic       ad_oe_q, ad_oe_d;
   logic       sel_q, sel_d;
`ifdef BUS_RTC_ERROR_OCUPADO_EN
   logic       err_q, err_d;
`endif

   always_comb begin
      estado_d    = estado_q;
      cnt_d       = cnt_q;
      esc_d       = esc_q;
      direccion_d = direccion_q;
      dato_d      = dato_q;
      leido_d     = leido_q;
      listo_d     = 1'b0;
      // cnt_q holds the cycles left in the current phase after this one.
      case (estado_q)
         IDLE: if (inicio) begin
            estado_d    = DIR;
            cnt_d       = L_ALE - 8'd1;
            esc_d       = escritura;
            direccion_d = direccion_in;
            dato_d      = dato_in;
         end
         DIR: if (cnt_q == 8'd0) begin
            estado_d = RET;
            cnt_d    = L_HOLD - 8'd1;
         end else cnt_d = cnt_q - 8'd1;
         RET: if (cnt_q == 8'd0) begin
            estado_d = esc_q ? ESC : LEE;
            cnt_d    = L_PULSO - 8'd1;
         end else cnt_d = cnt_q - 8'd1;
         ESC: if (cnt_q == 8'd0) begin
            estado_d = REC;
            cnt_d    = L_REC - 8'd1;
         end else cnt_d = cnt_q - 8'd1;
         LEE: if (cnt_q == 8'd0) begin
            estado_d = REC;
            cnt_d    = L_REC - 8'd1;
            leido_d  = bus_in;
         end else cnt_d = cnt_q - 8'd1;
         REC: if (cnt_q == 8'd0) begin
            estado_d = IDLE;
            cnt_d    = 8'd0;
            listo_d  = 1'b1;
         end else cnt_d = cnt_q - 8'd1;
         default: begin
            estado_d = IDLE;
            cnt_d    = 8'd0;
         end
      endcase

      // Strobes are decoded from the next state so they register alongside it.
      cs_n_d    = 1'b1;
      ale_d     = 1'b0;
      wr_n_d    = 1'b1;
      rd_n_d    = 1'b1;
      ad_oe_d   = 1'b0;
      sel_d     = 1'b0;
      ocupado_d = (estado_d != IDLE);
      case (estado_d)
         DIR: begin cs_n_d = 1'b0; ale_d = 1'b1; ad_oe_d = 1'b1; end
         RET: begin cs_n_d = 1'b0; ad_oe_d = 1'b1; end
         ESC: begin cs_n_d = 1'b0; wr_n_d = 1'b0; ad_oe_d = 1'b1; sel_d = 1'b1; end
         LEE: begin cs_n_d = 1'b0; rd_n_d = 1'b0; end
         default: ;
      endcase
`ifdef BUS_RTC_ERROR_OCUPADO_EN
      err_d = inicio & ocupado_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q    <= IDLE;
         cnt_q       <= 8'd0;
         esc_q       <= 1'b0;
         direccion_q <= 8'd0;
         dato_q      <= 8'd0;
         leido_q     <= 8'd0;
         listo_q     <= 1'b0;
         ocupado_q   <= 1'b0;
         cs_n_q      <= 1'b1;
         ale_q       <= 1'b0;
         wr_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         ad_oe_q     <= 1'b0;
         sel_q       <= 1'b0;
`ifdef BUS_RTC_ERROR_OCUPADO_EN
         err_q       <= 1'b0;
`endif
      end else begin
         estado_q    <= estado_d;
         cnt_q       <= cnt_d;
         esc_q       <= esc_d;
         direccion_q <= direccion_d;
         dato_q      <= dato_d;
         leido_q     <= leido_d;
         listo_q     <= listo_d;
         ocupado_q   <= ocupado_d;
         cs_n_q      <= cs_n_d;
         ale_q       <= ale_d;
         wr_n_q      <= wr_n_d;
         rd_n_q      <= rd_n_d;
         ad_oe_q     <= ad_oe_d;
         sel_q       <= sel_d;
`ifdef BUS_RTC_ERROR_OCUPADO_EN
         err_q       <= err_d;
`endif
      end
   end

   assign direccion  = direccion_q;
   assign dato       = dato_q;
   assign seleccion  = sel_q;
   assign ad_oe      = ad_oe_q;
   assign cs_n       = cs_n_q;
   assign ale        = ale_q;
   assign wr_n       = wr_n_q;
   assign rd_n       = rd_n_q;
   assign dato_leido = leido_q;
   assign ocupado    = ocupado_q;
   assign listo      = listo_q;
   assign estado_dbg = estado_q;
`ifdef BUS_RTC_ERROR_OCUPADO_EN
   assign error_ocupado = err_q;
`endif

endmodule

// File: tb/tb_secuenciador_bus_rtc.sv
// Bench for secuenciador_bus_rtc: per-cycle strobe vectors from a table plus
// hand-written reset-abort and short-pulse sequences.
module tb_secuenciador_bus_rtc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       inicio, escritura;
   logic [7:0] direccion_in, dato_in, bus_in;
   logic [7:0] direccion, dato, dato_leido;
   logic       seleccion, ad_oe, cs_n, ale, wr_n, rd_n, ocupado, listo;
   logic [2:0] estado_dbg;
   logic [7:0] direccion2, dato2, dato_leido2;
   logic       seleccion2, ad_oe2, cs_n2, ale2, wr_n2, rd_n2, ocupado2, listo2;
   logic [2:0] estado_dbg2;
`ifdef BUS_RTC_ERROR_OCUPADO_EN
   logic       error_ocupado, error_ocupado2;
   int         err_cnt = 0;
`endif

   always #5 clk = ~clk;

   secuenciador_bus_rtc dut (
      .clk(clk), .rst_n(rst_n), .inicio(inicio), .escritura(escritura),
      .direccion_in(direccion_in), .dato_in(dato_in), .bus_in(bus_in),
      .direccion(direccion), .dato(dato), .seleccion(seleccion), .ad_oe(ad_oe),
      .cs_n(cs_n), .ale(ale), .wr_n(wr_n), .rd_n(rd_n), .dato_leido(dato_leido),
      .ocupado(ocupado),
`ifdef BUS_RTC_ERROR_OCUPADO_EN
      .error_ocupado(error_ocupado),
`endif
      .listo(listo), .estado_dbg(estado_dbg)
   );

   secuenciador_bus_rtc #(.T_PULSO(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .inicio(inicio), .escritura(escritura),
      .direccion_in(direccion_in), .dato_in(dato_in), .bus_in(bus_in),
      .direccion(direccion2), .dato(dato2), .seleccion(seleccion2), .ad_oe(ad_oe2),
      .cs_n(cs_n2), .ale(ale2), .wr_n(wr_n2), .rd_n(rd_n2), .dato_leido(dato_leido2),
      .ocupado(ocupado2),
`ifdef BUS_RTC_ERROR_OCUPADO_EN
      .error_ocupado(error_ocupado2),
`endif
      .listo(listo2), .estado_dbg(estado_dbg2)
   );

`ifdef BUS_RTC_ERROR_OCUPADO_EN
   always @(negedge clk) if (error_ocupado) err_cnt++;
`endif

   // Observed strobes packed as {cs_n, ale, wr_n, rd_n, ad_oe, seleccion, ocupado, listo}.
   logic [7:0] obs, mux_out;
   assign obs     = {cs_n, ale, wr_n, rd_n, ad_oe, seleccion, ocupado, listo};
   assign mux_out = seleccion ? dato : direccion;

   typedef struct {
      logic       esc;
      int         step;
      logic [7:0] exp;
   } vec_t;
   vec_t tab[20];

   int         total = 0;
   int         bad   = 0;
   logic [7:0] last_leido = 8'h00;

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic start(input logic esc, input logic [7:0] d, input logic [7:0] w);
      escritura    = esc;
      direccion_in = d;
      dato_in      = w;
      inicio       = 1'b1;
      bus_in       = 8'hFF;
      @(negedge clk);
   endtask

   // Called at the negedge of cycle 1 after the accepting edge; checks cycles 1..10.
   task automatic follow(input logic esc, input logic [7:0] d, input logic [7:0] w,
                         input logic [7:0] rb, input bit keep, input int pulse_at,
                         input logic nesc, input logic [7:0] nd, input logic [7:0] nw);
      for (int i = 1; i <= 10; i++) begin
         vec_t v;
         v = tab[(esc ? 0 : 10) + i - 1];
         chk8($sformatf("strobes %s c%0d", esc ? "wr" : "rd", v.step), obs, v.exp);
         chk8($sformatf("direccion c%0d", i), direccion, d);
         chk8($sformatf("dato c%0d", i), dato, w);
         if (v.exp[3]) chk8($sformatf("mux c%0d", i), mux_out, v.exp[2] ? w : d);
         if (i == 10) begin
            if (!esc) last_leido = rb;
            chk8("dato_leido at listo", dato_leido, last_leido);
         end
         inicio = keep || (i == pulse_at);
         if (keep && i == 10) begin
            escritura    = nesc;
            direccion_in = nd;
            dato_in      = nw;
         end else begin
            escritura    = ~esc;
            direccion_in = ~d;
            dato_in      = ~w;
         end
         bus_in = (!esc && i >= 4 && i <= 7) ? rb : 8'hFF;
         @(negedge clk);
      end
   endtask

   initial begin
      int low2, ocu2, listo_at, listo_seen, ocu_seen;
      tab[0]  = '{1'b1, 1, 8'b0111_1010};
      tab[1]  = '{1'b1, 2, 8'b0111_1010};
      tab[2]  = '{1'b1, 3, 8'b0011_1010};
      tab[3]  = '{1'b1, 4, 8'b0001_1110};
      tab[4]  = '{1'b1, 5, 8'b0001_1110};
      tab[5]  = '{1'b1, 6, 8'b0001_1110};
      tab[6]  = '{1'b1, 7, 8'b0001_1110};
      tab[7]  = '{1'b1, 8, 8'b1011_0010};
      tab[8]  = '{1'b1, 9, 8'b1011_0010};
      tab[9]  = '{1'b1, 10, 8'b1011_0001};
      tab[10] = '{1'b0, 1, 8'b0111_1010};
      tab[11] = '{1'b0, 2, 8'b0111_1010};
      tab[12] = '{1'b0, 3, 8'b0011_1010};
      tab[13] = '{1'b0, 4, 8'b0010_0010};
      tab[14] = '{1'b0, 5, 8'b0010_0010};
      tab[15] = '{1'b0, 6, 8'b0010_0010};
      tab[16] = '{1'b0, 7, 8'b0010_0010};
      tab[17] = '{1'b0, 8, 8'b1011_0010};
      tab[18] = '{1'b0, 9, 8'b1011_0010};
      tab[19] = '{1'b0, 10, 8'b1011_0001};

      rst_n = 1'b0; inicio = 1'b0; escritura = 1'b0;
      direccion_in = 8'h00; dato_in = 8'h00; bus_in = 8'hFF;
      repeat (3) @(negedge clk);
      chk8("reset strobes", obs, 8'b1011_0000);
      chk8("reset direccion", direccion, 8'h00);
      chk8("reset dato", dato, 8'h00);
      chk8("reset dato_leido", dato_leido, 8'h00);
      chk8("reset estado", {5'd0, estado_dbg}, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      chk8("idle strobes", obs, 8'b1011_0000);

      // Write 0x21 <- 0x45
      start(1'b1, 8'h21, 8'h45);
      follow(1'b1, 8'h21, 8'h45, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h00);

      // Read 0x33, pad returns 0x5A during LEE only
      start(1'b0, 8'h33, 8'h77);
      follow(1'b0, 8'h33, 8'h77, 8'h5A, 1'b0, 0, 1'b0, 8'h00, 8'h00);

      // Back-to-back writes with inicio held high
      start(1'b1, 8'h10, 8'h11);
      follow(1'b1, 8'h10, 8'h11, 8'h00, 1'b1, 0, 1'b1, 8'h20, 8'h22);
      follow(1'b1, 8'h20, 8'h22, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h00);

      // Stray inicio in cycle 3 of an active write
      repeat (2) @(negedge clk);
`ifdef BUS_RTC_ERROR_OCUPADO_EN
      err_cnt = 0;
`endif
      start(1'b1, 8'h44, 8'h55);
      follow(1'b1, 8'h44, 8'h55, 8'h00, 1'b0, 3, 1'b0, 8'h00, 8'h00);
`ifdef BUS_RTC_ERROR_OCUPADO_EN
      chk8("error_ocupado pulses", 8'(err_cnt), 8'd1);
`endif

      // Reset asserted during ESC
      start(1'b1, 8'h66, 8'h77);
      inicio = 1'b0;
      repeat (3) @(negedge clk);
      chk8("pre-abort in ESC", {7'd0, wr_n}, 8'd0);
      rst_n = 1'b0;
      @(negedge clk);
      chk8("abort strobes", obs, 8'b1011_0000);
      chk8("abort dato_leido", dato_leido, 8'h00);
      rst_n = 1'b1;
      listo_seen = 0;
      ocu_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         listo_seen += int'(listo);
         ocu_seen += int'(ocupado);
      end
      chk8("no listo after abort", 8'(listo_seen), 8'd0);
      chk8("no ocupado after abort", 8'(ocu_seen), 8'd0);
      last_leido = 8'h00;

      // T_PULSO=0 instance
      start(1'b1, 8'h12, 8'h34);
      low2 = 0; ocu2 = 0; listo_at = 0;
      for (int i = 1; i <= 12; i++) begin
         low2 += int'(!wr_n2);
         ocu2 += int'(ocupado2);
         if (listo2 && listo_at == 0) listo_at = i;
         inicio = 1'b0;
         @(negedge clk);
      end
      chk8("t_pulso0 strobe cycles", 8'(low2), 8'd1);
      chk8("t_pulso0 ocupado cycles", 8'(ocu2), 8'd6);
      chk8("t_pulso0 listo cycle", 8'(listo_at), 8'd7);
      chk8("t_pulso0 direccion", direccion2, 8'h12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
